// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer and the datapath it drives:
// states, opcodes, ALU operation and register-mux codes, decoded control word.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    StFetch     = 3'b000,
    StDecode    = 3'b001,
    StExecute   = 3'b010,
    StMem       = 3'b011,
    StWriteback = 3'b100
  } state_e;

  localparam logic [3:0] OpcBz     = 4'b1000;
  localparam logic [3:0] OpcBnz    = 4'b1001;
  localparam logic [3:0] OpcBc     = 4'b1010;
  localparam logic [3:0] OpcBnc    = 4'b1011;
  localparam logic [3:0] OpcLoad   = 4'b1100;
  localparam logic [3:0] OpcStore  = 4'b1101;
  localparam logic [3:0] OpcRtype  = 4'b1110;
  localparam logic [3:0] OpcPortIn = 4'b1111;

  localparam logic [3:0] AluOpAdd = 4'b0000;

  localparam logic [1:0] RegMuxAlu  = 2'b00;
  localparam logic [1:0] RegMuxMem  = 2'b01;
  localparam logic [1:0] RegMuxPort = 2'b10;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       op2;
    logic [1:0] reg_mux;
    logic       reg_wrt;
    logic       is_mem;
    logic       mem_we;
    logic       is_branch;
    logic       illegal;
  } ctrl_t;

  // Branch condition is encoded in opc[1:0]: bz, bnz, bc, bnc.
  function automatic logic branch_taken(input logic [1:0] cond, input logic zero,
                                        input logic carry);
    case (cond)
      2'b00:   return zero;
      2'b01:   return !zero;
      2'b10:   return carry;
      default: return !carry;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// Combinational decode of the latched opcode/function into a control word.
module instr_decoder
  import control_sequencer_pkg::*;
(
  input  logic [3:0] opc_i,
  input  logic [2:0] func_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    casez (opc_i)
      4'b00??: begin
        ctrl_o.alu_op  = {2'b00, opc_i[1:0]};
        ctrl_o.reg_mux = RegMuxAlu;
        ctrl_o.reg_wrt = 1'b1;
      end
      OpcRtype: begin
        ctrl_o.alu_op  = {1'b0, func_i};
        ctrl_o.op2     = 1'b1;
        ctrl_o.reg_mux = RegMuxAlu;
        ctrl_o.reg_wrt = 1'b1;
      end
      OpcLoad: begin
        ctrl_o.alu_op  = AluOpAdd;
        ctrl_o.reg_mux = RegMuxMem;
        ctrl_o.reg_wrt = 1'b1;
        ctrl_o.is_mem  = 1'b1;
      end
      OpcStore: begin
        ctrl_o.alu_op = AluOpAdd;
        ctrl_o.is_mem = 1'b1;
        ctrl_o.mem_we = 1'b1;
      end
      OpcPortIn: begin
        ctrl_o.reg_mux = RegMuxPort;
        ctrl_o.reg_wrt = 1'b1;
      end
      4'b10??: ctrl_o.is_branch = 1'b1;
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with a bus-stall
// watchdog; outputs are decoded from registered state and latched instruction.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned STALL_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ClkEn_i,
  input  logic [3:0] opc_i,
  input  logic [2:0] func_i,
  input  logic       carry_i,
  input  logic       zero_i,
  input  logic       inst_ack_i,
  input  logic       data_ack_i,
  output logic       inst_stb_o,
  output logic       inst_cyc_o,
  output logic       data_stb_o,
  output logic       data_we_o,
  output logic [1:0] RegMux_c_o,
  output logic       RegWrt_c_o,
  output logic       op2_c_o,
  output logic [3:0] ALUOp_c_o,
  output logic       pc_en_o,
  output logic       pc_sel_o,
  output logic       bus_err_o,
  output logic       illegal_o,
  output logic [2:0] state_o
);

  localparam int unsigned CntW = $clog2(STALL_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STALL_MAX);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      opc_q;
  logic [2:0]      func_q;
  logic            taken_q;
  ctrl_t           ctrl;
  logic            timeout;

  instr_decoder u_instr_decoder (
    .opc_i  (opc_q),
    .func_i (func_q),
    .ctrl_o (ctrl)
  );

  // A full count means the request has been dropped for this cycle.
  assign timeout = (cnt_q == CntMax);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      opc_q   <= '0;
      func_q  <= '0;
      taken_q <= 1'b0;
    end else if (ClkEn_i) begin
      unique case (state_q)
        StFetch: begin
          if (timeout) begin
            cnt_q <= '0;
          end else if (inst_ack_i) begin
            cnt_q   <= '0;
            state_q <= StDecode;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDecode: begin
          opc_q   <= opc_i;
          func_q  <= func_i;
          state_q <= StExecute;
        end
        StExecute: begin
          taken_q <= ctrl.is_branch && branch_taken(opc_q[1:0], zero_i, carry_i);
          state_q <= ctrl.is_mem ? StMem : StWriteback;
        end
        StMem: begin
          if (timeout) begin
            cnt_q   <= '0;
            state_q <= StFetch;
          end else if (data_ack_i) begin
            cnt_q   <= '0;
            state_q <= StWriteback;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWriteback: begin
          taken_q <= 1'b0;
          state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    inst_stb_o = 1'b0;
    inst_cyc_o = 1'b0;
    data_stb_o = 1'b0;
    data_we_o  = 1'b0;
    RegMux_c_o = '0;
    RegWrt_c_o = 1'b0;
    op2_c_o    = 1'b0;
    ALUOp_c_o  = '0;
    pc_en_o    = 1'b0;
    pc_sel_o   = 1'b0;
    bus_err_o  = 1'b0;
    illegal_o  = 1'b0;
    state_o    = '0;
    if (rst_i) begin
      state_o = state_q;
      if (state_q inside {StExecute, StMem, StWriteback}) begin
        ALUOp_c_o  = ctrl.alu_op;
        op2_c_o    = ctrl.op2;
        RegMux_c_o = ctrl.reg_mux;
      end
      unique case (state_q)
        StFetch: begin
          inst_stb_o = !timeout;
          inst_cyc_o = !timeout;
          bus_err_o  = ClkEn_i && timeout;
        end
        StExecute: illegal_o = ClkEn_i && ctrl.illegal;
        StMem: begin
          data_stb_o = !timeout;
          data_we_o  = !timeout && ctrl.mem_we;
          bus_err_o  = ClkEn_i && timeout;
        end
        StWriteback: begin
          RegWrt_c_o = ClkEn_i && ctrl.reg_wrt;
          pc_en_o    = ClkEn_i;
          pc_sel_o   = taken_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: the driver queues expected write/PC/error events with their
// cycle numbers, and a negedge monitor pops and compares each event the DUT shows.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_i, ClkEn_i, carry_i, zero_i, inst_ack_i, data_ack_i;
  logic [3:0] opc_i;
  logic [2:0] func_i;
  logic       inst_stb_o, inst_cyc_o, data_stb_o, data_we_o;
  logic [1:0] RegMux_c_o;
  logic       RegWrt_c_o, op2_c_o, pc_en_o, pc_sel_o, bus_err_o, illegal_o;
  logic [3:0] ALUOp_c_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  control_sequencer #(.STALL_MAX(15)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .ClkEn_i    (ClkEn_i),
    .opc_i      (opc_i),
    .func_i     (func_i),
    .carry_i    (carry_i),
    .zero_i     (zero_i),
    .inst_ack_i (inst_ack_i),
    .data_ack_i (data_ack_i),
    .inst_stb_o (inst_stb_o),
    .inst_cyc_o (inst_cyc_o),
    .data_stb_o (data_stb_o),
    .data_we_o  (data_we_o),
    .RegMux_c_o (RegMux_c_o),
    .RegWrt_c_o (RegWrt_c_o),
    .op2_c_o    (op2_c_o),
    .ALUOp_c_o  (ALUOp_c_o),
    .pc_en_o    (pc_en_o),
    .pc_sel_o   (pc_sel_o),
    .bus_err_o  (bus_err_o),
    .illegal_o  (illegal_o),
    .state_o    (state_o)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic        pc_en;
    logic        pc_sel;
    logic        bus_err;
    logic        ill;
    logic [3:0]  alu;
    logic        op2;
    logic [1:0]  mux;
  } ev_t;

  // opc, func, zero, carry, data-ack delay, freeze cycles, spurious acks,
  // expected alu, op2, mux, write, pc_sel, illegal, mem cycle, mem write.
  typedef struct packed {
    logic [3:0] opc;
    logic [2:0] func;
    logic       z;
    logic       c;
    logic [3:0] ddly;
    logic [3:0] freeze;
    logic       spur;
    logic [3:0] alu;
    logic       op2;
    logic [1:0] mux;
    logic       wr;
    logic       sel;
    logic       ill;
    logic       mem;
    logic       we;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs [NVec] = '{
    '{4'b0000, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{4'b0011, 3'd5, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'b0011, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{4'b1110, 3'd3, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'b0011, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{4'b1110, 3'd7, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'b0111, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{4'b1100, 3'd0, 1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
    '{4'b1101, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
    '{4'b1111, 3'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{4'b1000, 3'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{4'b1000, 3'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{4'b1001, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{4'b1010, 3'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{4'b1011, 3'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{4'b0111, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
    '{4'b0001, 3'd0, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 4'b0001, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
  };

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d wr=%b pc_en=%b pc_sel=%b bus_err=%b ill=%b alu=%b op2=%b mux=%b",
                     e.cyc, e.wr, e.pc_en, e.pc_sel, e.bus_err, e.ill, e.alu, e.op2, e.mux);
  endfunction

  always @(negedge clk) begin : monitor
    ev_t got, want;
    if (RegWrt_c_o || pc_en_o || bus_err_o || illegal_o) begin
      got = '{cyc: cyc, wr: RegWrt_c_o, pc_en: pc_en_o, pc_sel: pc_sel_o, bus_err: bus_err_o,
              ill: illegal_o, alu: ALUOp_c_o, op2: op2_c_o, mux: RegMux_c_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event: got unexpected %s, expected no event", fmt(got));
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL event: got %s, expected %s", fmt(got), fmt(want));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({inst_stb_o, inst_cyc_o, data_stb_o, data_we_o, RegMux_c_o, RegWrt_c_o, op2_c_o,
                ALUOp_c_o, pc_en_o, pc_sel_o, bus_err_o, illegal_o, state_o});
  endfunction

  task automatic wait_fetch();
    for (int i = 0; i < 40 && !(state_o == 3'd0 && inst_stb_o); i++) tick();
    check("fetch ready", 32'(state_o == 3'd0 && inst_stb_o), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int   k, f, wb;
    ev_t  e;
    wait_fetch();
    k  = int'(cyc);
    f  = int'(v.freeze);
    // Ack cycle k; DECODE k+1 (+freeze), EXECUTE, then MEM or WRITEBACK.
    wb = v.mem ? k + 4 + f + int'(v.ddly) : k + 3 + f;
    if (v.ill) begin
      e = '0; e.cyc = 32'(k + 2 + f); e.ill = 1'b1;
      exp_q.push_back(e);
    end
    e = '0; e.cyc = 32'(wb); e.wr = v.wr; e.pc_en = 1'b1; e.pc_sel = v.sel;
    e.alu = v.alu; e.op2 = v.op2; e.mux = v.mux;
    exp_q.push_back(e);

    opc_i = v.opc; func_i = v.func; zero_i = v.z; carry_i = v.c; inst_ack_i = 1'b1;
    check("inst_stb in fetch", 32'(inst_stb_o && inst_cyc_o), 1);
    tick();
    inst_ack_i = v.spur;
    data_ack_i = v.spur && !v.mem;
    check("state decode", 32'(state_o), 1);
    check("inst_stb after ack", 32'(inst_stb_o), 0);
    if (f > 0) begin
      ClkEn_i = 1'b0;
      repeat (f) begin
        tick();
        check("state frozen", 32'(state_o), 1);
      end
      ClkEn_i = 1'b1;
    end
    tick();
    opc_i = ~v.opc; func_i = ~v.func;
    check("state execute", 32'(state_o), 2);
    check("ctrl execute", 32'({ALUOp_c_o, op2_c_o, RegMux_c_o}), 32'({v.alu, v.op2, v.mux}));
    if (v.mem) begin
      tick();
      check("state mem", 32'(state_o), 3);
      check("data_stb/we", 32'({data_stb_o, data_we_o}), 32'({1'b1, v.we}));
      repeat (int'(v.ddly)) tick();
      data_ack_i = 1'b1;
      tick();
      data_ack_i = 1'b0;
    end else begin
      tick();
    end
    check("state writeback", 32'(state_o), 4);
    check("ctrl writeback", 32'({ALUOp_c_o, op2_c_o, RegMux_c_o}), 32'({v.alu, v.op2, v.mux}));
    inst_ack_i = 1'b0;
    data_ack_i = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin : driver
    int  f;
    ev_t e;
    rst_i = 1'b0; ClkEn_i = 1'b1; opc_i = '0; func_i = '0;
    carry_i = 1'b0; zero_i = 1'b0; inst_ack_i = 1'b0; data_ack_i = 1'b0;
    repeat (3) tick();
    check("outputs in reset", all_outs(), 0);
    rst_i = 1'b1;
    #1;
    check("inst_stb after release", 32'({inst_stb_o, state_o}), 32'({1'b1, 3'd0}));

    for (int i = 0; i < NVec; i++) run_vec(vecs[i]);

    // Instruction bus never acknowledges: error pulse on the 16th FETCH cycle.
    wait_fetch();
    f = int'(cyc);
    e = '0; e.cyc = 32'(f + 15); e.bus_err = 1'b1;
    exp_q.push_back(e);
    repeat (15) tick();
    check("request dropped on stall", 32'({inst_stb_o, state_o}), 32'({1'b0, 3'd0}));
    tick();
    check("fetch retried after stall", 32'({inst_stb_o, state_o}), 32'({1'b1, 3'd0}));

    // Reset during EXECUTE of a subc aborts the write.
    opc_i = 4'b1110; func_i = 3'd3; inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    tick();
    check("state before reset", 32'(state_o), 2);
    rst_i = 1'b0;
    #1;
    check("outputs in mid reset", all_outs(), 0);
    tick();
    rst_i = 1'b1;
    #1;
    check("fetch after mid reset", 32'({inst_stb_o, state_o}), 32'({1'b1, 3'd0}));

    run_vec(vecs[0]);
    repeat (5) tick();
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
